led_mode_seq: RTL

LED_MODE_SEQ -- requirements
Module: led_mode_seq

---
 rtl/led_mode_pkg.sv | 23 ++
 rtl/sw_debounce.sv | 54 +++++
 rtl/led_mode_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_mode_pkg.sv
// Shared encodings for the LED mode sequencer.
//   mode_e : pattern mode selected by the two low switch bits
//   dir_e  : travel direction of the BOUNCE pattern
//   SW_*   : positions of the meaningful switch bits
package led_mode_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam int unsigned SW_MODE_LSB = 0;
  localparam int unsigned SW_RUN_BIT  = 2;
  localparam int unsigned SW_USED     = 3;

endpackage

// File: rtl/sw_debounce.sv
// Per-bit switch conditioner: 2-flop synchronizer followed by a stability
// counter. A bit's debounced output follows the synchronized input once the
// two have differed for DEB_CYCLES consecutive cycles; any agreeing cycle
// restarts the count. Edge-to-output latency is 2+DEB_CYCLES cycles.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_raw   : raw asynchronous switch inputs
//   o_deb   : registered debounced values
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned WIDTH      = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_deb
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_deb;
  logic [CW-1:0]    r_cnt [WIDTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
      r_deb  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_sync[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEB_CYCLES - 1)) begin
          // The current cycle is the DEB_CYCLES-th differing one.
          r_deb[i] <= r_sync[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/led_mode_seq.sv
// LED pattern sequencer. Debounced switches select one of four patterns
// (BINARY count, CHASE rotate, BOUNCE ping-pong, BLINK invert) and a run
// enable. A prescaler divides clk by TICK_DIV; each wrap advances the
// pattern by one step. A debounced mode change reloads the new mode's start
// value, clears the prescaler and resets the bounce direction.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   sw    : raw switches; sw[1:0] mode, sw[2] run, higher bits ignored
//   led   : registered LED pattern
module led_mode_seq
  import led_mode_pkg::*;
#(
  parameter int unsigned N_SW       = 3,
  parameter int unsigned N_LED      = 4,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TICK_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SW-1:0]  sw,
  output logic [N_LED-1:0] led
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [SW_USED-1:0] w_deb;
  mode_e              w_mode;
  logic               w_run;
  logic               w_reload;
  logic               w_tick;
  logic [N_LED-1:0]   w_next;
  dir_e               w_dir_next;

  mode_e              r_mode_q;
  dir_e               r_dir;
  logic [PW-1:0]      r_presc;
  logic [N_LED-1:0]   r_pattern;

  sw_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .WIDTH      (SW_USED)
  ) u_sw_debounce (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_raw   (sw[SW_USED-1:0]),
    .o_deb   (w_deb)
  );

  if (N_SW > SW_USED) begin : g_ignored_sw
    logic w_unused_sw;
    assign w_unused_sw = ^sw[N_SW-1:SW_USED];
  end

  assign w_mode = mode_e'(w_deb[SW_MODE_LSB +: 2]);
  assign w_run  = w_deb[SW_RUN_BIT];

  // r_mode_q is the mode the pattern register currently belongs to, so a
  // mismatch is seen exactly on the edge after the debounced mode changes.
  assign w_reload = (w_mode != r_mode_q);
  assign w_tick   = w_run && (r_presc == PW'(TICK_DIV - 1));

  function automatic logic [N_LED-1:0] start_value(input mode_e m);
    logic [N_LED-1:0] v;
    unique case (m)
      MODE_BINARY: v = '0;
      MODE_CHASE:  v = N_LED'(1);
      MODE_BOUNCE: v = N_LED'(1);
      MODE_BLINK:  v = '1;
    endcase
    return v;
  endfunction

  always_comb begin
    w_next     = r_pattern;
    w_dir_next = r_dir;
    unique case (r_mode_q)
      MODE_BINARY: w_next = r_pattern + 1'b1;
      MODE_CHASE:  w_next = {r_pattern[N_LED-2:0], r_pattern[N_LED-1]};
      MODE_BOUNCE: begin
        // Turn around on arrival at an end so the end position is shown once.
        if (r_dir == DIR_LEFT) begin
          w_next = r_pattern << 1;
          if (w_next[N_LED-1]) w_dir_next = DIR_RIGHT;
        end else begin
          w_next = r_pattern >> 1;
          if (w_next[0]) w_dir_next = DIR_LEFT;
        end
      end
      MODE_BLINK:  w_next = ~r_pattern;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q  <= MODE_BINARY;
      r_dir     <= DIR_LEFT;
      r_presc   <= '0;
      r_pattern <= '0;
    end else begin
      r_mode_q <= w_mode;
      if (w_reload) begin
        // Reload wins over a coincident tick; that tick is dropped.
        r_pattern <= start_value(w_mode);
        r_presc   <= '0;
        r_dir     <= DIR_LEFT;
      end else begin
        if (w_run) begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
        if (w_tick) begin
          r_pattern <= w_next;
          r_dir     <= w_dir_next;
        end
      end
    end
  end

  assign led = r_pattern;

endmodule
